// File: rtl/mem_access_if.sv
// RAM request/response bus between the MEM stage and the data RAM.
// The master side issues requests; the slave side reports ready.
interface mem_access_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready;

  modport master (
    output ram_en,
    output ram_write_en,
    output ram_addr,
    output ram_write_data,
    input  ram_ready
  );

  modport slave (
    input  ram_en,
    input  ram_write_en,
    input  ram_addr,
    input  ram_write_data,
    output ram_ready
  );
endinterface

// File: rtl/mem_access.sv
// TinyMIPS MEM stage: aligned RAM request generation, ready/enable handshake
// with wait-timeout, and the MEM/WB pipeline register.
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               mem_read_flag_in,
  input  logic               mem_write_flag_in,
  input  logic               mem_sign_ext_flag_in,
  input  logic [3:0]         mem_sel_in,
  input  logic [31:0]        mem_write_data,
  input  logic [31:0]        result_in,
  input  logic               reg_write_en_in,
  input  logic [4:0]         reg_write_addr_in,
  input  logic [31:0]        current_pc_addr_in,
  mem_access_if.master       ram,
  output logic               stall_req,
  output logic               bus_error,
  output logic               mem_read_flag_out,
  output logic               mem_write_flag_out,
  output logic               mem_sign_ext_flag_out,
  output logic [3:0]         mem_sel_out,
  output logic [31:0]        result_out,
  output logic               reg_write_en_out,
  output logic [4:0]         reg_write_addr_out,
  output logic [31:0]        current_pc_addr_out
);

  localparam logic [7:0] TO = TIMEOUT[7:0];

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        sx;
    logic [3:0]  sel;
    logic [31:0] result;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] pc;
  } memwb_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_error_q, bus_error_d;
  logic        accepted_q, accepted_d;
  memwb_t      memwb_q, memwb_d;

  logic        is_word;
  logic        aligned;
  logic        access;
  logic        wait_expired;
  logic        timeout;
  logic        ram_en_c;
  logic [3:0]  ram_we_c;
  logic [31:0] ram_addr_c;
  logic [31:0] ram_wdata_c;
  logic        stall_c;
  memwb_t      memwb_in;

  // Request side; everything is gated by rst so the bus is quiet in reset.
  always_comb begin
    is_word      = (mem_sel_in == 4'b1111);
    aligned      = is_word ? (result_in[1:0] == 2'b00) : 1'b1;
    // accepted_q masks a request the RAM already took while stall_in held MEM/WB.
    access       = rst & (mem_read_flag_in | mem_write_flag_in) & aligned
                   & ~flush & ~accepted_q;
    wait_expired = (state_q == WAIT) && (cnt_q == TO);
    stall_c      = access & ~ram.ram_ready & ~wait_expired;
    timeout      = access & ~ram.ram_ready & wait_expired;

    ram_en_c    = access;
    ram_addr_c  = rst ? {result_in[31:2], 2'b00} : '0;
    ram_we_c    = '0;
    ram_wdata_c = '0;
    if (access && mem_write_flag_in) begin
      if (is_word) begin
        ram_we_c    = 4'b1111;
        ram_wdata_c = mem_write_data;
      end else begin
        ram_we_c    = 4'b0001 << result_in[1:0];
        ram_wdata_c = {4{mem_write_data[7:0]}};
      end
    end
  end

  assign ram.ram_en         = ram_en_c;
  assign ram.ram_write_en   = ram_we_c;
  assign ram.ram_addr       = ram_addr_c;
  assign ram.ram_write_data = ram_wdata_c;
  assign stall_req          = stall_c;

  always_comb begin
    memwb_in = '{rd:     mem_read_flag_in,
                 wr:     mem_write_flag_in,
                 sx:     mem_sign_ext_flag_in,
                 sel:    mem_sel_in,
                 result: result_in,
                 we:     reg_write_en_in,
                 waddr:  reg_write_addr_in,
                 pc:     current_pc_addr_in};

    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access && !ram.ram_ready) begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (!access || ram.ram_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO) begin
          state_d     = IDLE;
          cnt_d       = '0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (flush) begin
      accepted_d = 1'b0;
    end else if (stall_in) begin
      accepted_d = accepted_q | (ram_en_c & ram.ram_ready);
    end else begin
      accepted_d = 1'b0;
    end

    if (flush) begin
      memwb_d = '0;
    end else if (stall_in) begin
      memwb_d = memwb_q;
    end else if (stall_c) begin
      memwb_d = '0;
    end else if (timeout) begin
      memwb_d    = memwb_in;
      memwb_d.we = 1'b0;
    end else begin
      memwb_d = memwb_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
      accepted_q  <= 1'b0;
      memwb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
      accepted_q  <= accepted_d;
      memwb_q     <= memwb_d;
    end
  end

  assign bus_error             = bus_error_q;
  assign mem_read_flag_out     = memwb_q.rd;
  assign mem_write_flag_out    = memwb_q.wr;
  assign mem_sign_ext_flag_out = memwb_q.sx;
  assign mem_sel_out           = memwb_q.sel;
  assign result_out            = memwb_q.result;
  assign reg_write_en_out      = memwb_q.we;
  assign reg_write_addr_out    = memwb_q.waddr;
  assign current_pc_addr_out   = memwb_q.pc;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT overridden to 4).
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        flush;
  logic        rd_in, wr_in, sx_in;
  logic [3:0]  sel_in;
  logic [31:0] wdata_in;
  logic [31:0] res_in;
  logic        we_in;
  logic [4:0]  waddr_in;
  logic [31:0] pc_in;

  logic        stall_req, bus_error;
  logic        rd_out, wr_out, sx_out;
  logic [3:0]  sel_out;
  logic [31:0] res_out;
  logic        we_out;
  logic [4:0]  waddr_out;
  logic [31:0] pc_out;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int w0;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_in             (stall_in),
    .flush                (flush),
    .mem_read_flag_in     (rd_in),
    .mem_write_flag_in    (wr_in),
    .mem_sign_ext_flag_in (sx_in),
    .mem_sel_in           (sel_in),
    .mem_write_data       (wdata_in),
    .result_in            (res_in),
    .reg_write_en_in      (we_in),
    .reg_write_addr_in    (waddr_in),
    .current_pc_addr_in   (pc_in),
    .ram                  (bus),
    .stall_req            (stall_req),
    .bus_error            (bus_error),
    .mem_read_flag_out    (rd_out),
    .mem_write_flag_out   (wr_out),
    .mem_sign_ext_flag_out(sx_out),
    .mem_sel_out          (sel_out),
    .result_out           (res_out),
    .reg_write_en_out     (we_out),
    .reg_write_addr_out   (waddr_out),
    .current_pc_addr_out  (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted RAM writes, as the RAM itself would see them.
  always @(posedge clk)
    if (bus.ram_en && bus.ram_ready && bus.ram_write_en != 4'b0000)
      wr_count <= wr_count + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                       input logic [31:0] wd, input logic [31:0] res, input logic we,
                       input logic [4:0] wa, input logic [31:0] pc);
    rd_in = rd; wr_in = wr; sx_in = sx; sel_in = sel; wdata_in = wd;
    res_in = res; we_in = we; waddr_in = wa; pc_in = pc;
  endtask

  task automatic nop(input logic [31:0] res);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, res, 1'b1, 5'd3, 32'h1000);
  endtask

  // Word load with RAM never ready: 4 stall cycles, then abort and error pulse.
  task automatic timeout_seq(input logic [31:0] addr, input string tag);
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, addr, 1'b1, 5'd9, 32'h2000);
    bus.ram_ready = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_stall"}, {31'b0, stall_req}, 32'd1);
      check({tag, "_err_lo"}, {31'b0, bus_error}, 32'd0);
      tick();
      check({tag, "_bubble_we"}, {31'b0, we_out}, 32'd0);
    end
    check({tag, "_stall_drop"}, {31'b0, stall_req}, 32'd0);
    tick();
    check({tag, "_err_pulse"}, {31'b0, bus_error}, 32'd1);
    check({tag, "_abort_we"}, {31'b0, we_out}, 32'd0);
    check({tag, "_abort_rd"}, {31'b0, rd_out}, 32'd1);
    check({tag, "_abort_res"}, res_out, addr);
    nop(32'h0);
    tick();
    check({tag, "_err_end"}, {31'b0, bus_error}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    bus.ram_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h104, 1'b1, 5'd7, 32'h40);
    #3;
    check("rst_ram_en", {31'b0, bus.ram_en}, 32'd0);
    check("rst_ram_we", {28'b0, bus.ram_write_en}, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    tick();
    check("rst_res_out", res_out, 32'd0);
    check("rst_we_out", {31'b0, we_out}, 32'd0);
    check("rst_wr_out", {31'b0, wr_out}, 32'd0);
    check("rst_buserr", {31'b0, bus_error}, 32'd0);
    rst = 1'b1;

    // 1: zero-wait word load
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h100, 1'b1, 5'd5, 32'h400);
    #1;
    check("t1_ram_en", {31'b0, bus.ram_en}, 32'd1);
    check("t1_ram_addr", bus.ram_addr, 32'h100);
    check("t1_ram_we", {28'b0, bus.ram_write_en}, 32'd0);
    check("t1_stall", {31'b0, stall_req}, 32'd0);
    tick();
    check("t1_rd_out", {31'b0, rd_out}, 32'd1);
    check("t1_sx_out", {31'b0, sx_out}, 32'd1);
    check("t1_res_out", res_out, 32'h100);
    check("t1_wa_out", {27'b0, waddr_out}, 32'd5);
    check("t1_pc_out", pc_out, 32'h400);

    // 2: byte and word stores
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 32'h12345678, 32'h203, 1'b0, 5'd0, 32'h404);
    #1;
    check("t2_ram_we", {28'b0, bus.ram_write_en}, 32'h8);
    check("t2_ram_wd", bus.ram_write_data, 32'h78787878);
    check("t2_ram_addr", bus.ram_addr, 32'h200);
    tick();
    check("t2_wr_out", {31'b0, wr_out}, 32'd1);
    check("t2_sel_out", {28'b0, sel_out}, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 32'h000000AB, 32'h201, 1'b0, 5'd0, 32'h408);
    #1;
    check("t2b_ram_we", {28'b0, bus.ram_write_en}, 32'h2);
    check("t2b_ram_wd", bus.ram_write_data, 32'hABABABAB);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h204, 1'b0, 5'd0, 32'h40C);
    #1;
    check("t2c_ram_we", {28'b0, bus.ram_write_en}, 32'hF);
    check("t2c_ram_wd", bus.ram_write_data, 32'hCAFEF00D);
    tick();

    // 3: load with three wait cycles
    w0 = wr_count;
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h300, 1'b1, 5'd8, 32'h410);
    bus.ram_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t3_stall", {31'b0, stall_req}, 32'd1);
      tick();
      check("t3_bubble_we", {31'b0, we_out}, 32'd0);
      check("t3_bubble_rd", {31'b0, rd_out}, 32'd0);
    end
    bus.ram_ready = 1'b1;
    #1;
    check("t3_stall_drop", {31'b0, stall_req}, 32'd0);
    check("t3_ram_en", {31'b0, bus.ram_en}, 32'd1);
    tick();
    check("t3_we_out", {31'b0, we_out}, 32'd1);
    check("t3_res_out", res_out, 32'h300);
    check("t3_no_write", wr_count, w0);

    // 4: timeout abort
    timeout_seq(32'h500, "t4");

    // 5: misaligned word store and load
    bus.ram_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'h11223344, 32'h202, 1'b0, 5'd0, 32'h420);
    #1;
    check("t5_ram_en", {31'b0, bus.ram_en}, 32'd0);
    check("t5_ram_we", {28'b0, bus.ram_write_en}, 32'd0);
    check("t5_stall", {31'b0, stall_req}, 32'd0);
    tick();
    check("t5_wr_out", {31'b0, wr_out}, 32'd1);
    check("t5_res_out", res_out, 32'h202);
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h101, 1'b1, 5'd2, 32'h424);
    #1;
    check("t5b_ram_en", {31'b0, bus.ram_en}, 32'd0);
    tick();

    // 6a: ready store while stall_in holds MEM/WB -> exactly one write
    nop(32'h777);
    #1;
    check("t6_nop_ram_en", {31'b0, bus.ram_en}, 32'd0);
    tick();
    check("t6_nop_res", res_out, 32'h777);
    w0 = wr_count;
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'hA5A5A5A5, 32'h600, 1'b0, 5'd0, 32'h430);
    stall_in = 1'b1;
    #1;
    check("t6_ram_en", {31'b0, bus.ram_en}, 32'd1);
    tick();
    check("t6_held_res", res_out, 32'h777);
    check("t6_req_dropped", {31'b0, bus.ram_en}, 32'd0);
    tick();
    check("t6_req_dropped2", {31'b0, bus.ram_en}, 32'd0);
    stall_in = 1'b0;
    #1;
    check("t6_no_rerequest", {31'b0, bus.ram_en}, 32'd0);
    tick();
    check("t6_res_out", res_out, 32'h600);
    check("t6_wr_out", {31'b0, wr_out}, 32'd1);
    check("t6_one_write", wr_count, w0 + 1);

    // 6b: flush mid-WAIT
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h700, 1'b1, 5'd4, 32'h440);
    bus.ram_ready = 1'b0;
    #1;
    check("t6f_stall", {31'b0, stall_req}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    check("t6f_ram_en", {31'b0, bus.ram_en}, 32'd0);
    check("t6f_stall", {31'b0, stall_req}, 32'd0);
    tick();
    check("t6f_bub_we", {31'b0, we_out}, 32'd0);
    check("t6f_bub_rd", {31'b0, rd_out}, 32'd0);
    flush = 1'b0;
    nop(32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6f_no_err", {31'b0, bus_error}, 32'd0);
    end

    // 6c: async reset mid-WAIT, then full-length timeout proves IDLE and counter 0
    bus.ram_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h900, 1'b1, 5'd6, 32'h450);
    tick();
    check("t6r_res_pre", res_out, 32'h900);
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h800, 1'b1, 5'd6, 32'h454);
    bus.ram_ready = 1'b0;
    stall_in = 1'b1;
    tick();
    tick();
    check("t6r_held", res_out, 32'h900);
    #2;
    rst = 1'b0;
    #1;
    check("t6r_res", res_out, 32'd0);
    check("t6r_we", {31'b0, we_out}, 32'd0);
    check("t6r_rd", {31'b0, rd_out}, 32'd0);
    check("t6r_pc", pc_out, 32'd0);
    check("t6r_ram_en", {31'b0, bus.ram_en}, 32'd0);
    check("t6r_stall", {31'b0, stall_req}, 32'd0);
    check("t6r_err", {31'b0, bus_error}, 32'd0);
    tick();
    rst = 1'b1;
    timeout_seq(32'h800, "t6r");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the TinyMIPS pipeline, directly upstream of the write-back stage.
- Turns EX load/store info into aligned RAM requests (address, byte enables, lane-replicated store data) and runs a ready/enable handshake with the RAM, stalling the pipeline while RAM is busy.
- Holds the MEM/WB pipeline register, which feeds the write-back stage.
- Load data is not captured here: RAM returns it combinationally in the cycle after acceptance, and WB consumes it.

Parameters:
- TIMEOUT, 16: max consecutive cycles of waiting for ram_ready before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall_in  in  1  downstream/hazard hold; MEM/WB register keeps its value
- flush  in  1  discard current instruction; MEM/WB register loads a bubble
- mem_read_flag_in  in  1  load in MEM
- mem_write_flag_in  in  1  store in MEM
- mem_sign_ext_flag_in  in  1  sign-extend load
- mem_sel_in  in  4  4'b0001 byte access, 4'b1111 word access
- mem_write_data  in  32  store source register value
- result_in  in  32  ALU result / effective address
- reg_write_en_in  in  1
- reg_write_addr_in  in  5
- current_pc_addr_in  in  32
- ram_ready  in  1  RAM accepts the request at this edge
- ram_en  out  1  request valid
- ram_write_en  out  4  per-byte write strobes
- ram_addr  out  32  word-aligned address {result_in[31:2],2'b00}
- ram_write_data  out  32
- stall_req  out  1  to the pipeline controller
- bus_error  out  1  one-cycle pulse on timeout
- mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out  out  1 each  registered
- mem_sel_out  out  4  registered
- result_out  out  32  registered
- reg_write_en_out  out  1  registered
- reg_write_addr_out  out  5  registered
- current_pc_addr_out  out  32  registered

Behaviour:
- Reset (rst=0, async): state IDLE, wait counter 0, bus_error 0, and every registered output 0. Combinational RAM outputs are 0 while in reset.
- access = (mem_read_flag_in | mem_write_flag_in) & aligned & !flush.
  - aligned = 1 for byte accesses.
  - For word accesses, aligned = (result_in[1:0] == 0).
- Misaligned word access:
  - No RAM request is made.
  - Flags still pass to WB unchanged, so WB produces 0.
  - Misaligned stores write nothing.
- Combinational RAM outputs:
  - ram_en = access.
  - ram_write_en = 0 for loads and when there is no access.
  - Byte store: ram_write_en = 4'b0001 << result_in[1:0].
  - Word store: ram_write_en = 4'b1111.
  - ram_write_data: byte store = mem_write_data[7:0] replicated 4x; word store = mem_write_data.
- FSM states: IDLE and WAIT.
  - IDLE: if access & !ram_ready, go to WAIT and set counter to 1.
  - WAIT: request outputs stay driven from the inputs, which upstream holds because of stall_req.
  - WAIT: on ram_ready, go to IDLE.
  - WAIT: if counter == TIMEOUT and !ram_ready, go to IDLE, pulse bus_error for 1 cycle, and clear counter. Otherwise counter increments.
- stall_req = access & !ram_ready & !(state==WAIT & counter==TIMEOUT). It is combinational, so zero-wait RAM gives no stall.
- MEM/WB register priority (per edge):
  - flush beats stall_in, which beats a waiting access, which beats a normal load.
  - flush: bubble, i.e. all flags, reg_write_en and mem_sel = 0; data fields hold don't-care (implementation: 0).
  - stall_in (no flush): hold all values.
  - stall_req = 1: bubble.
  - Timeout abort: load the instruction with reg_write_en forced to 0.
  - Otherwise: load all *_in fields.
- Acceptance and latency:
  - Acceptance = an edge with ram_en & ram_ready.
  - The instruction reaches WB at that same edge; load data is valid in WB during the following cycle.
  - Latency is 1 cycle for zero-wait RAM, and 1+N cycles for N wait cycles.
- stall_in while ram_en & ram_ready: the RAM still accepts (it is not held off). Upstream must hold the inputs, and the request is deasserted via a one-bit "accepted" flag until the MEM/WB register loads. This avoids a duplicate store.
- flush during WAIT: ram_en drops in the same cycle, FSM returns to IDLE, counter clears, no bus_error.
- Async reset mid-WAIT: outputs clear immediately; no partial store is guaranteed beyond the RAM's own acceptance.
- Non-memory instructions pass through with no stall; ram_en = 0.

Test Plan:
1. Word load, addr 0x100, ram_ready=1 -> ram_en=1, ram_addr=0x100, ram_write_en=0, stall_req=0; next cycle mem_read_flag_out=1, result_out=0x100.
2. Byte store, addr 0x203, data 0x12345678 -> ram_write_en=4'b1000, ram_write_data=0x78787878, ram_addr=0x200.
3. Word load, ram_ready held low for 3 cycles -> stall_req=1 for 3 cycles, with bubbles in the MEM/WB register (reg_write_en_out=0); on the 4th cycle ready -> instruction enters the register, stall_req=0.
4. TIMEOUT=4, ram_ready stuck low -> after 4 wait cycles bus_error pulses for exactly 1 cycle, stall_req drops, reg_write_en_out=0.
5. Word store at 0x202 (misaligned) -> ram_en=0, ram_write_en=0, mem_write_flag_out=1.
6. stall_in=1 plus ready store, then flush mid-WAIT, then rst=0 mid-WAIT -> one single RAM write accepted; flush bubble with ram_en=0 and no bus_error; after reset all outputs 0 and state IDLE.
